// File: rtl/adder_pkg.sv
// Shared constants for the pipelined adder/subtractor.
//   WIDTH_DEF / STAGES_DEF : default operand width and pipeline depth
//   OP_ADD / OP_SUB        : encoding of the 'sub' input
//   chunk_width()          : bits handled by each pipeline stage
package adder_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned STAGES_DEF = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned chunk_width(int unsigned width, int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CW-bit add of one operand chunk with carry in/out.
//   a, b : chunk operands
//   ci   : carry from the previous chunk
//   s    : chunk sum
//   co   : carry into the next chunk
module add_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co
);

    assign {co, s} = (CW+1)'(a) + (CW+1)'(b) + (CW+1)'(ci);

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one CW-bit chunk per stage, with a
// valid/ready handshake on both sides and a whole-pipeline stall.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (a, b, cin, sub)
//   out_valid/out_ready : output handshake (sum, cout, ovf)
//   sub                 : 0 = a + b + cin, 1 = a - b - cin (cin is borrow-in)
//   cout                : carry out of the top chunk (1 = no borrow on subtract)
//   ovf                 : two's-complement signed overflow
module pipelined_add_sub
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = chunk_width(WIDTH, STAGES);

    if ((STAGES == 0) || (WIDTH < 8) || (WIDTH > 64) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_add_sub: WIDTH must be 8..64 and a multiple of STAGES");
    end

    // Whole pipeline moves together; it only freezes when the result is stuck.
    logic advance;
    assign in_ready = out_ready | ~out_valid;
    assign advance  = in_ready;

    // Subtract folds into the adder as a + ~b + !cin; the inverted operand and
    // carry travel with the operation, so add and subtract can interleave freely.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    always_comb begin
        b_eff   = b;
        cin_eff = cin;
        if (sub == OP_SUB) begin
            b_eff   = ~b;
            cin_eff = ~cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operands arrive pre-shifted so the chunk for this stage sits in the
        // low CW bits; finished result chunks enter from the top and shift down.
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] sum_src;
        logic             c_src;
        logic             v_src;
        logic [CW-1:0]    s_chunk;
        logic             co_chunk;

        logic             valid_d, valid_q;
        logic             carry_d, carry_q;
        logic [WIDTH-1:0] sum_d, sum_q;

        if (k == 0) begin : g_src
            assign a_src   = a;
            assign b_src   = b_eff;
            assign c_src   = cin_eff;
            assign v_src   = in_valid;
            assign sum_src = '0;
        end else begin : g_src
            assign a_src   = g_stage[k-1].g_fwd.a_q;
            assign b_src   = g_stage[k-1].g_fwd.b_q;
            assign c_src   = g_stage[k-1].carry_q;
            assign v_src   = g_stage[k-1].valid_q;
            assign sum_src = g_stage[k-1].sum_q;
        end

        add_chunk #(.CW(CW)) u_add_chunk (
            .a  (CW'(a_src)),
            .b  (CW'(b_src)),
            .ci (c_src),
            .s  (s_chunk),
            .co (co_chunk)
        );

        // Stage result: valid bit always follows, payload only loads for real ops.
        always_comb begin
            valid_d = valid_q;
            carry_d = carry_q;
            sum_d   = sum_q;
            if (advance) begin
                valid_d = v_src;
                if (v_src) begin
                    carry_d = co_chunk;
                    sum_d   = (sum_src >> CW) | (WIDTH'(s_chunk) << (WIDTH - CW));
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Skew registers for the operand chunks later stages still need.
            logic [WIDTH-1:0] a_d, a_q;
            logic [WIDTH-1:0] b_d, b_q;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (advance && v_src) begin
                    a_d = a_src >> CW;
                    b_d = b_src >> CW;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_out
            // Signed overflow is decided by the top chunk's sign bits.
            logic ovf_d, ovf_q;

            always_comb begin
                ovf_d = ovf_q;
                if (advance && v_src) begin
                    ovf_d = (a_src[CW-1] == b_src[CW-1]) && (s_chunk[CW-1] != a_src[CW-1]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_out.ovf_q;

endmodule
